qif_frame_scheduler: RTL and testbench

Time-multiplexed controller for the 8-bit QIF neuron datapath. It keeps the state of N_NEUR virtual neurons in a register file and steps them round-robin through one shared QIF update unit, once per prescaled integration tick. It sits between the chip pins and the neuron arithmetic: it loads per-neuron input currents, sequences the updates, emits spike pulses and exposes one selectable membrane value for monitoring.

---
 rtl/qif_frame_scheduler_if.sv | 26 ++
 rtl/qif_frame_scheduler.sv | 135 +++++++++++++
 tb/tb_qif_frame_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qif_frame_scheduler_if.sv
// Pin-side bundle of the QIF frame scheduler: config writes, monitor select and status outputs.
// The master drives config and monitor select, and the slave (the scheduler) drives the status.
interface qif_frame_scheduler_if #(
  parameter int N_NEUR = 4
);
  logic              ena;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [7:0]        cfg_data;
  logic [1:0]        mon_sel;
  logic [7:0]        v_mon;
  logic [N_NEUR-1:0] spike;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  modport master (
    output ena, cfg_we, cfg_addr, cfg_data, mon_sel,
    input  v_mon, spike, busy, frame_done, overrun
  );

  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_data, mon_sel,
    output v_mon, spike, busy, frame_done, overrun
  );
endinterface

// File: rtl/qif_frame_scheduler.sv
// Round-robin scheduler that time-shares one QIF update unit across N_NEUR virtual neurons.
// One frame (a READ/WRITE pair per neuron, then DONE) runs on each prescaled integration tick.
module qif_frame_scheduler #(
  parameter int          N_NEUR   = 4,
  parameter logic [23:0] TICK_DIV = 24'd10_000_000,
  parameter logic [7:0]  V_TH     = 8'd200,
  parameter logic [7:0]  V_RESET  = 8'd0,
  parameter logic [7:0]  LEAK     = 8'd1
) (
  input logic                   clk,
  input logic                   rst_n,
  qif_frame_scheduler_if.slave  bus
);
  localparam int CW = $clog2(N_NEUR);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_reg;
  logic [CW-1:0] ch_reg;
  logic [23:0] count_reg;
  logic [7:0]  op_v_reg;
  logic [7:0]  op_i_reg;
  logic [7:0]  v_reg [N_NEUR];
  logic [7:0]  i_reg [N_NEUR];
  logic [7:0]  v_mon_reg;
  logic [N_NEUR-1:0] spike_reg;
  logic        busy_reg;
  logic        frame_done_reg;
  logic        overrun_reg;

  logic        tick;
  logic [15:0] prod;
  logic [9:0]  sum;
  logic [9:0]  net;
  logic        fire;
  logic [7:0]  v_new;
  logic [N_NEUR-1:0] v_we;
  logic [N_NEUR-1:0] i_we;

  assign tick = bus.ena && (count_reg == TICK_DIV - 24'd1);

  // Shared update unit, fed only from the operand registers latched in READ.
  assign prod  = 16'(op_v_reg) * 16'(op_v_reg);
  assign sum   = 10'(op_v_reg) + 10'(prod >> 8) + 10'(op_i_reg);
  assign net   = (sum >= {2'b00, LEAK}) ? sum - {2'b00, LEAK} : 10'd0;
  assign fire  = (net >= {2'b00, V_TH});
  assign v_new = fire ? V_RESET : net[7:0];

  generate
    for (genvar gi = 0; gi < N_NEUR; gi++) begin : g_we
      assign v_we[gi] = (state_reg == S_WRITE) && (ch_reg == CW'(gi));
      assign i_we[gi] = bus.cfg_we && (bus.cfg_addr == CW'(gi));
    end
  endgenerate

  // Register file: a config write in a READ cycle lands after READ has sampled the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEUR; n++) begin
        v_reg[n] <= V_RESET;
        i_reg[n] <= 8'd0;
      end
    end else begin
      for (int n = 0; n < N_NEUR; n++) begin
        if (i_we[n]) i_reg[n] <= bus.cfg_data;
        if (v_we[n]) v_reg[n] <= v_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      ch_reg         <= '0;
      count_reg      <= 24'd0;
      op_v_reg       <= 8'd0;
      op_i_reg       <= 8'd0;
      v_mon_reg      <= 8'd0;
      spike_reg      <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      spike_reg      <= '0;
      frame_done_reg <= 1'b0;
      v_mon_reg      <= v_reg[bus.mon_sel];

      if (bus.ena) count_reg <= (count_reg == TICK_DIV - 24'd1) ? 24'd0 : count_reg + 24'd1;

      // DONE is the frame's last cycle, so a tick there chains straight into the next frame.
      if (tick && (state_reg == S_READ || state_reg == S_WRITE)) overrun_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (tick) begin
            state_reg <= S_READ;
            ch_reg    <= '0;
            busy_reg  <= 1'b1;
          end
        end
        S_READ: begin
          op_v_reg  <= v_reg[ch_reg];
          op_i_reg  <= i_reg[ch_reg];
          state_reg <= S_WRITE;
        end
        S_WRITE: begin
          spike_reg <= fire ? (N_NEUR'(1) << ch_reg) : '0;
          if (ch_reg == CW'(N_NEUR - 1)) begin
            state_reg <= S_DONE;
          end else begin
            ch_reg    <= ch_reg + 1'b1;
            state_reg <= S_READ;
          end
        end
        S_DONE: begin
          frame_done_reg <= 1'b1;
          if (tick) begin
            state_reg <= S_READ;
            ch_reg    <= '0;
          end else begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.v_mon      = v_mon_reg;
  assign bus.spike      = spike_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_qif_frame_scheduler.sv
// Directed bench for qif_frame_scheduler: main instance at TICK_DIV=16, plus 8 and 9 for overrun.
module tb_qif_frame_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qif_frame_scheduler_if #(.N_NEUR(4)) bus16 ();
  qif_frame_scheduler_if #(.N_NEUR(4)) bus8 ();
  qif_frame_scheduler_if #(.N_NEUR(4)) bus9 ();

  qif_frame_scheduler #(.N_NEUR(4), .TICK_DIV(24'd16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  qif_frame_scheduler #(.N_NEUR(4), .TICK_DIV(24'd8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  qif_frame_scheduler #(.N_NEUR(4), .TICK_DIV(24'd9))  dut9  (.clk(clk), .rst_n(rst_n), .bus(bus9));

  int checks = 0;
  int failures = 0;

  task automatic init_inputs();
    bus16.ena = 0; bus16.cfg_we = 0; bus16.cfg_addr = 0; bus16.cfg_data = 0; bus16.mon_sel = 0;
    bus8.ena  = 0; bus8.cfg_we  = 0; bus8.cfg_addr  = 0; bus8.cfg_data  = 0; bus8.mon_sel  = 0;
    bus9.ena  = 0; bus9.cfg_we  = 0; bus9.cfg_addr  = 0; bus9.cfg_data  = 0; bus9.mon_sel  = 0;
  endtask

  task automatic do_reset();
    bus16.ena = 0; bus8.ena = 0; bus9.ena = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus16.cfg_we = 1; bus16.cfg_addr = a; bus16.cfg_data = d;
    @(negedge clk);
    bus16.cfg_we = 0;
    $display("cfg write I[%0d]=%0d", a, d);
  endtask

  // Leaves the bench at the negedge of cycle T+1 (first busy cycle of a frame).
  task automatic wait_frame_start();
    int n = 0;
    while (bus16.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (bus16.busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus16.busy !== 1'b1) begin
      failures++;
      $display("FAIL frame_start_timeout busy=%b expected=1", bus16.busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cfg_write(2'd0, 8'd50);
    bus16.mon_sel = 0;
    bus16.ena = 1;
    wait_frame_start();
    repeat (4) @(negedge clk);
    checks++;
    if (bus16.v_mon !== 8'd49) begin
      failures++; $display("FAIL reset_pre_vmon got=%0d expected=49", bus16.v_mon);
    end
    wait_frame_start();
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus16.busy, bus16.spike, bus16.frame_done, bus16.overrun, bus16.v_mon} !== 15'd0) begin
      failures++;
      $display("FAIL reset_async busy=%b spike=%b fd=%b ovr=%b vmon=%0d expected all 0",
               bus16.busy, bus16.spike, bus16.frame_done, bus16.overrun, bus16.v_mon);
    end
    $display("reset asserted mid-frame: busy=%b v_mon=%0d", bus16.busy, bus16.v_mon);
    @(negedge clk);
    rst_n = 1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (bus16.busy !== 1'b0 || bus16.v_mon !== 8'd0) begin
        failures++;
        $display("FAIL reset_after_release cyc=%0d busy=%b vmon=%0d expected busy=0 vmon=0",
                 j, bus16.busy, bus16.v_mon);
      end
    end
  endtask

  task automatic test_trajectory();
    logic [7:0] exp_v [3];
    int spk_cnt;
    int spk_cyc;
    exp_v[0] = 8'd49; exp_v[1] = 8'd107; exp_v[2] = 8'd0;
    do_reset();
    cfg_write(2'd0, 8'd50);
    bus16.mon_sel = 0;
    bus16.ena = 1;
    for (int f = 0; f < 3; f++) begin
      wait_frame_start();
      spk_cnt = 0; spk_cyc = -1;
      for (int j = 2; j <= 11; j++) begin
        @(negedge clk);
        if (bus16.spike[0] === 1'b1) begin spk_cnt++; spk_cyc = j; end
        if (j == 4) begin
          checks++;
          if (bus16.v_mon !== exp_v[f]) begin
            failures++; $display("FAIL traj_v frame=%0d got=%0d expected=%0d", f + 1, bus16.v_mon, exp_v[f]);
          end
          $display("trajectory frame %0d: V0=%0d", f + 1, bus16.v_mon);
        end
      end
      checks++;
      if (spk_cnt !== ((f == 2) ? 1 : 0) || (f == 2 && spk_cyc !== 3)) begin
        failures++;
        $display("FAIL traj_spike frame=%0d count=%0d at T+%0d expected count=%0d at T+3",
                 f + 1, spk_cnt, spk_cyc, (f == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_sequencing();
    logic [3:0] exp_spk;
    int busy_cnt = 0;
    do_reset();
    for (int k = 0; k < 4; k++) cfg_write(2'(k), 8'd255);
    bus16.ena = 1;
    wait_frame_start();
    for (int j = 1; j <= 11; j++) begin
      if (j > 1) @(negedge clk);
      exp_spk = 4'd0;
      for (int k = 0; k < 4; k++) if (j == 2 * k + 3) exp_spk[k] = 1'b1;
      if (bus16.busy === 1'b1) busy_cnt++;
      checks++;
      if (bus16.spike !== exp_spk || bus16.busy !== (j <= 9) || bus16.frame_done !== (j == 10)) begin
        failures++;
        $display("FAIL seq_T+%0d spike=%b busy=%b fd=%b expected spike=%b busy=%b fd=%b",
                 j, bus16.spike, bus16.busy, bus16.frame_done, exp_spk, j <= 9, j == 10);
      end
    end
    checks++;
    if (busy_cnt !== 9) begin
      failures++; $display("FAIL seq_busy_len got=%0d expected=9", busy_cnt);
    end
    $display("sequencing frame: busy cycles=%0d", busy_cnt);
  endtask

  task automatic test_collision();
    do_reset();
    bus16.mon_sel = 2;
    bus16.ena = 1;
    wait_frame_start();
    repeat (4) @(negedge clk);
    bus16.cfg_we = 1; bus16.cfg_addr = 2; bus16.cfg_data = 8'd100;
    @(negedge clk);
    bus16.cfg_we = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus16.v_mon !== 8'd0) begin
      failures++; $display("FAIL collision_same_frame got=%0d expected=0", bus16.v_mon);
    end
    $display("collision frame: V2=%0d", bus16.v_mon);
    wait_frame_start();
    repeat (7) @(negedge clk);
    checks++;
    if (bus16.v_mon !== 8'd99) begin
      failures++; $display("FAIL collision_next_frame got=%0d expected=99", bus16.v_mon);
    end
    $display("collision next frame: V2=%0d", bus16.v_mon);
  endtask

  task automatic test_overrun();
    int fd8 = 0;
    int fd9 = 0;
    do_reset();
    bus8.ena = 1;
    bus9.ena = 1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n <= 30 && bus8.frame_done === 1'b1) fd8++;
      if (bus9.frame_done === 1'b1) fd9++;
      if (n == 15 || n == 16) begin
        checks++;
        if (bus8.overrun !== (n == 16)) begin
          failures++; $display("FAIL overrun8_R+%0d got=%b expected=%b", n, bus8.overrun, n == 16);
        end
      end
    end
    checks++;
    if (fd8 !== 1) begin
      failures++; $display("FAIL overrun8_dropped frame_done count=%0d expected=1", fd8);
    end
    checks++;
    if (bus8.overrun !== 1'b1) begin
      failures++; $display("FAIL overrun8_sticky got=%b expected=1", bus8.overrun);
    end
    checks++;
    if (fd9 !== 10 || bus9.overrun !== 1'b0) begin
      failures++; $display("FAIL overrun9 frames=%0d ovr=%b expected frames=10 ovr=0", fd9, bus9.overrun);
    end
    $display("overrun: div8 ovr=%b frames=%0d, div9 ovr=%b frames=%0d", bus8.overrun, fd8, bus9.overrun, fd9);
    bus8.ena = 0;
    bus9.ena = 0;
  endtask

  task automatic test_ena_gating();
    int busy_seen = 0;
    int first_busy = -1;
    do_reset();
    bus16.ena = 1;
    wait_frame_start();
    @(negedge clk);
    bus16.ena = 0;
    for (int j = 3; j <= 11; j++) begin
      @(negedge clk);
      checks++;
      if (bus16.frame_done !== (j == 10)) begin
        failures++; $display("FAIL ena_frame_T+%0d fd=%b expected=%b", j, bus16.frame_done, j == 10);
      end
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus16.busy === 1'b1) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      failures++; $display("FAIL ena_no_tick busy cycles=%0d expected=0", busy_seen);
    end
    bus16.ena = 1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (first_busy < 0 && bus16.busy === 1'b1) first_busy = n;
    end
    checks++;
    if (first_busy !== 15) begin
      failures++; $display("FAIL ena_resume first busy at R+%0d expected R+15", first_busy);
    end
    $display("ena gating: resumed frame at R+%0d", first_busy);
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_trajectory();
    test_sequencing();
    test_collision();
    test_overrun();
    test_ena_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
